// File: rtl/memstage_if.sv
// EX/MEM-to-MEM/WB bundle for the memory-access stage: EX/MEM register outputs in,
// branch decision and MEM/WB register outputs back.
interface memstage_if;
  logic        exmregwrite;
  logic        exmmemtoreg;
  logic        exmbranch;
  logic        exmmemwrite;
  logic        exmbgtz;
  logic [7:0]  addresult;
  logic [31:0] exmaluresult;
  logic [31:0] exmr2_dout;
  logic [4:0]  exmrd;

  logic        pcsrc;
  logic [7:0]  branchtarget;
  logic        flush;
  logic        memwbregwrite;
  logic        memwbmemtoreg;
  logic [31:0] memwbreaddata;
  logic [31:0] memwbaluresult;
  logic [4:0]  memwbrd;
  logic [31:0] wbdata;

  modport master (
    output exmregwrite, exmmemtoreg, exmbranch, exmmemwrite, exmbgtz,
           addresult, exmaluresult, exmr2_dout, exmrd,
    input  pcsrc, branchtarget, flush, memwbregwrite, memwbmemtoreg,
           memwbreaddata, memwbaluresult, memwbrd, wbdata
  );

  modport slave (
    input  exmregwrite, exmmemtoreg, exmbranch, exmmemwrite, exmbgtz,
           addresult, exmaluresult, exmr2_dout, exmrd,
    output pcsrc, branchtarget, flush, memwbregwrite, memwbmemtoreg,
           memwbreaddata, memwbaluresult, memwbrd, wbdata
  );
endinterface

// File: rtl/memstage.sv
// MIPS MEM stage: word-addressed data memory, branch decision and the MEM/WB register
// with its write-back mux.
module memstage #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  memstage_if.slave bus
);

  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic [31:0] readdata;
    logic [31:0] aluresult;
    logic [4:0]  rd;
  } memwb_t;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] widx;
  logic [31:0]   rd_data;
  memwb_t        memwb_d;
  memwb_t        memwb_q;
  logic          unused_addr_bits;

  // Byte offset and bits above the index are dropped, so addresses wrap modulo DEPTH.
  assign widx             = bus.exmaluresult[AW+1:2];
  assign unused_addr_bits = ^{bus.exmaluresult[31:AW+2], bus.exmaluresult[1:0]};
  assign rd_data          = mem_q[widx];

  // NOTE: no reset branch on the array -- contents must survive rst_n, and a reset
  // loop over every word would turn the RAM into a huge bank of resettable flops.
  always_ff @(posedge clk) begin
    if (rst_n && bus.exmmemwrite) begin
      mem_q[widx] <= bus.exmr2_dout;
    end
  end

  always_comb begin
    // NOTE: give every field a value before any conditional logic so no latch is inferred.
    memwb_d           = '0;
    memwb_d.regwrite  = bus.exmregwrite;
    memwb_d.memtoreg  = bus.exmmemtoreg;
    memwb_d.readdata  = rd_data;
    memwb_d.aluresult = bus.exmaluresult;
    memwb_d.rd        = bus.exmrd;
  end

  // NOTE: non-blocking here so the load samples the pre-store word in the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memwb_q <= '0;
    end else begin
      memwb_q <= memwb_d;
    end
  end

  // Branch completes normally through MEM/WB; flush only targets the upstream registers.
  assign bus.pcsrc        = bus.exmbranch & bus.exmbgtz;
  assign bus.flush        = bus.exmbranch & bus.exmbgtz;
  assign bus.branchtarget = bus.addresult;

  assign bus.memwbregwrite  = memwb_q.regwrite;
  assign bus.memwbmemtoreg  = memwb_q.memtoreg;
  assign bus.memwbreaddata  = memwb_q.readdata;
  assign bus.memwbaluresult = memwb_q.aluresult;
  assign bus.memwbrd        = memwb_q.rd;
  assign bus.wbdata         = memwb_q.memtoreg ? memwb_q.readdata : memwb_q.aluresult;

endmodule
